// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO controller.
package sync_fifo_pkg;

    localparam int FWFT_STD = 0;
    localparam int FWFT_ON  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 8;
    localparam int PTR_W         = ptr_width(DEFAULT_DEPTH);
    localparam int CNT_W         = clog2(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port storage array: synchronous write, combinational (FWFT) or
// registered (standard) read port.
module fifo_ram_dp
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FWFT       = FWFT_STD,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (FWFT == FWFT_ON) begin : g_comb_rd
            logic unused_rd_sigs;
            assign unused_rd_sigs = rd_en ^ rst_n;
            assign rd_data = mem[rd_addr];
        end else begin : g_reg_rd
            // Read register samples the pre-write word when addresses collide.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     rd_data <= '0;
                else if (rd_en) rd_data <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error
// flags, synchronous flush and selectable first-word-fall-through read.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FWFT_STD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          flush,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_flush, rd_acc, wr_acc;
    logic                  ovf_set, udf_set;
    logic [DATA_WIDTH-1:0] ram_q;

    assign empty        = (cnt == '0);
    assign full         = (cnt == CW'(FIFO_DEPTH));
    assign almost_empty = (cnt <= CW'(AE_THRESH));
    assign almost_full  = (cnt >= CW'(AF_THRESH));
    assign count        = cnt;

    // Flush wins over any same-cycle access; dropped accesses raise no error.
    assign do_flush = cs & flush;
    assign rd_acc   = cs & rd_en & ~empty & ~do_flush;
    assign wr_acc   = cs & wr_en & (~full | rd_acc) & ~do_flush;
    assign ovf_set  = cs & wr_en & ~wr_acc & ~do_flush;
    assign udf_set  = cs & rd_en & empty & ~do_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Clear is applied first so a same-cycle set survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | ovf_set;
            underflow <= (underflow & ~clr_err) | udf_set;
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft_out
            assign data_out = empty ? '0 : ram_q;
        end else begin : g_std_out
            assign data_out = ram_q;
        end
    endgenerate

endmodule
